// File: rtl/rf_dump_ctrl.sv
// Read-side dump sequencer for a 2R/1W register file: walks a (possibly wrapping) address
// range on one read port and streams each captured word with its address over valid/ready.
module rf_dump_ctrl #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 32
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_start,
  input  logic [Depth-1:0] i_first_addr,
  input  logic [Depth-1:0] i_last_addr,
  output logic [Depth-1:0] o_rf_addr,
  input  logic [Width-1:0] i_rf_data,
  output logic [Width-1:0] o_out_data,
  output logic [Depth-1:0] o_out_addr,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRead = 2'd1;
  localparam logic [1:0] StHold = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam logic [Depth-1:0] AddrOne = {{(Depth-1){1'b0}}, 1'b1};

  logic [1:0]       r_state;
  logic [Depth-1:0] r_rf_addr;
  logic [Depth-1:0] r_last;
  logic [Width-1:0] r_out_data;
  logic [Depth-1:0] r_out_addr;
  logic             r_out_valid;
  logic             r_done;

  logic [1:0]       w_state_nxt;
  logic [Depth-1:0] w_rf_addr_nxt;
  logic [Depth-1:0] w_last_nxt;
  logic [Width-1:0] w_out_data_nxt;
  logic [Depth-1:0] w_out_addr_nxt;
  logic             w_out_valid_nxt;
  logic             w_done_nxt;

  always_comb begin
    w_state_nxt     = r_state;
    w_rf_addr_nxt   = r_rf_addr;
    w_last_nxt      = r_last;
    w_out_data_nxt  = r_out_data;
    w_out_addr_nxt  = r_out_addr;
    w_out_valid_nxt = r_out_valid;
    w_done_nxt      = 1'b0;
    case (r_state)
      StIdle: begin
        if (i_start) begin
          w_rf_addr_nxt = i_first_addr;
          w_last_nxt    = i_last_addr;
          w_state_nxt   = StRead;
        end
      end
      StRead: begin
        // Capture at this edge: a same-edge RF write is not yet visible on i_rf_data.
        w_out_data_nxt  = i_rf_data;
        w_out_addr_nxt  = r_rf_addr;
        w_out_valid_nxt = 1'b1;
        w_state_nxt     = StHold;
      end
      StHold: begin
        if (i_out_ready) begin
          w_out_valid_nxt = 1'b0;
          if (r_out_addr == r_last) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = StDone;
          end else begin
            w_rf_addr_nxt = r_rf_addr + AddrOne;
            w_state_nxt   = StRead;
          end
        end
      end
      StDone: begin
        w_state_nxt = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_state     <= StIdle;
      r_rf_addr   <= '0;
      r_last      <= '0;
      r_out_data  <= '0;
      r_out_addr  <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rf_addr   <= w_rf_addr_nxt;
      r_last      <= w_last_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_addr  <= w_out_addr_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_done      <= w_done_nxt;
    end
  end

  assign o_rf_addr   = r_rf_addr;
  assign o_out_data  = r_out_data;
  assign o_out_addr  = r_out_addr;
  assign o_out_valid = r_out_valid;
  assign o_done      = r_done;
  assign o_busy      = (r_state != StIdle);

endmodule
